clint_timer: RTL and testbench

// - Machine-level interrupt source for the core: 64-bit mtime counter, 64-bit mtimecmp, msip register, external IRQ synchroniser.
// - Drives mtip/msip/meip into the CSR file's mip bits. The CSR file gates them with mie/mstatus.MIE and raises traps.
// - Memory-mapped on the data bus as a single-outstanding 32-bit valid/ready slave.

---
 rtl/clint_pkg.sv | 57 +++++
 rtl/irq_synchronizer.sv | 23 ++
 rtl/clint_timer.sv | 152 +++++++++++++++
 tb/tb_clint_timer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT timer block: register offsets, reset values,
// bus window decode and byte-merge helpers.
package clint_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0200_0000;
  localparam int unsigned WINDOW_BITS       = 16;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } reg_sel_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strobe);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strobe[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // Addresses outside the 64 KiB window decode to SEL_NONE, same as unmapped offsets.
  function automatic reg_sel_e decode(input logic [31:0] base, input logic [31:0] address);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (address[31:WINDOW_BITS] == base[31:WINDOW_BITS]) begin
      case ({address[15:2], 2'b00})
        MSIP_OFF:        sel = SEL_MSIP;
        MTIMECMP_LO_OFF: sel = SEL_CMP_LO;
        MTIMECMP_HI_OFF: sel = SEL_CMP_HI;
        MTIME_LO_OFF:    sel = SEL_TIME_LO;
        MTIME_HI_OFF:    sel = SEL_TIME_HI;
        default:         sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_synchronizer.sv
// Multi-flop synchroniser for an asynchronous level interrupt input.
module irq_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic synced
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], level};
    end
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/clint_timer.sv
// Machine-level interrupt source: 64-bit mtime/mtimecmp, msip and external IRQ sync,
// exposed as a single-outstanding 32-bit valid/ready bus slave.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strobe,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error,
  input  logic        ext_irq,
  output logic        mtip,
  output logic        msip,
  output logic        meip
);

  localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  // Handshake: a request transfers on an edge where req_valid && req_ready; its response
  // appears after that edge and holds (valid, data, error) until resp_valid && resp_ready.
  bus_state_e  state;
  bus_state_e  state_next;
  reg_sel_e    sel;
  logic        accept;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata;

  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic [63:0]      mtime;
  logic [63:0]      mtime_next;
  logic [63:0]      mtimecmp;
  logic [63:0]      mtimecmp_next;
  logic [31:0]      shadow;

  assign resp_valid = (state == BUS_RESP);
  assign req_ready  = !resp_valid || resp_ready;
  assign accept     = req_valid && req_ready;
  assign wr_en      = accept && req_write;
  assign rd_en      = accept && !req_write;
  assign sel        = decode(BASE_ADDR, req_address);
  assign tick       = (prescaler == PRE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BUS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = BUS_RESP;
    end else if (resp_ready) begin
      state_next = BUS_IDLE;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_MSIP:    rdata = {31'b0, msip};
      SEL_CMP_LO:  rdata = mtimecmp[31:0];
      SEL_CMP_HI:  rdata = mtimecmp[63:32];
      SEL_TIME_LO: rdata = mtime[31:0];
      SEL_TIME_HI: rdata = shadow;
      default:     rdata = '0;
    endcase
  end

  // A bus write to either mtime half replaces that cycle's increment entirely.
  always_comb begin
    mtime_next = mtime;
    if (tick) begin
      mtime_next = mtime + 64'd1;
    end
    if (wr_en && sel == SEL_TIME_LO) begin
      mtime_next = {mtime[63:32], merge_bytes(mtime[31:0], req_wdata, req_strobe)};
    end else if (wr_en && sel == SEL_TIME_HI) begin
      mtime_next = {merge_bytes(mtime[63:32], req_wdata, req_strobe), mtime[31:0]};
    end
  end

  always_comb begin
    mtimecmp_next = mtimecmp;
    if (wr_en && sel == SEL_CMP_LO) begin
      mtimecmp_next = {mtimecmp[63:32], merge_bytes(mtimecmp[31:0], req_wdata, req_strobe)};
    end else if (wr_en && sel == SEL_CMP_HI) begin
      mtimecmp_next = {merge_bytes(mtimecmp[63:32], req_wdata, req_strobe), mtimecmp[31:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      mtime     <= '0;
      mtimecmp  <= MTIMECMP_RST;
      mtip      <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      mtime     <= mtime_next;
      mtimecmp  <= mtimecmp_next;
      mtip      <= (mtime_next >= mtimecmp_next);
    end
  end

  // Reading mtime lo latches the upper half so the following hi read is tear-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msip       <= 1'b0;
      shadow     <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      if (wr_en && sel == SEL_MSIP && req_strobe[0]) begin
        msip <= req_wdata[0];
      end
      if (rd_en && sel == SEL_TIME_LO) begin
        shadow <= mtime[63:32];
      end
      if (accept) begin
        resp_data  <= req_write ? 32'd0 : rdata;
        resp_error <= (sel == SEL_NONE);
      end
    end
  end

  irq_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .level (ext_irq),
    .synced(meip)
  );

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: register-map vector table plus hand-written
// sequences for timing, carry, strobes, interrupts and reset.
module tb_clint_timer;

  localparam int SYNC = 2;
  localparam logic [31:0] A_MSIP    = 32'h0200_0000;
  localparam logic [31:0] A_CMP_LO  = 32'h0200_4000;
  localparam logic [31:0] A_CMP_HI  = 32'h0200_4004;
  localparam logic [31:0] A_TIME_LO = 32'h0200_BFF8;
  localparam logic [31:0] A_TIME_HI = 32'h0200_BFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, resp_ready, ext_irq;
  logic [31:0] req_address, req_wdata;
  logic [3:0]  req_strobe;
  logic        req_ready, resp_valid, resp_error, mtip, msip, meip;
  logic [31:0] resp_data;
  logic        req_ready4, resp_valid4, resp_error4, mtip4, msip4, meip4;
  logic [31:0] resp_data4;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [32:0] exp_q[$];
  logic [31:0] cap4 = '0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs[16];

  clint_timer #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(1), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
    .req_strobe(req_strobe), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_error(resp_error), .ext_irq(ext_irq),
    .mtip(mtip), .msip(msip), .meip(meip)
  );

  clint_timer #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
    .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
    .req_strobe(req_strobe), .resp_valid(resp_valid4), .resp_ready(resp_ready),
    .resp_data(resp_data4), .resp_error(resp_error4), .ext_irq(ext_irq),
    .mtip(mtip4), .msip(msip4), .meip(meip4)
  );

  // Clock, cycle counter and watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver: must be called just after a rising edge; returns 1 time unit after the accept edge.
  task automatic bus_op(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strobe, input logic [31:0] exp_data, input logic exp_err);
    logic rdy;
    int   waited;
    req_valid   = 1'b1;
    req_write   = write;
    req_address = addr;
    req_wdata   = wdata;
    req_strobe  = strobe;
    exp_q.push_back({exp_err, exp_data});
    waited = 0;
    rdy = 1'b0;
    while (!rdy && waited < 50) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL bus_accept: got no accept expected accept within 50 cycles (addr %0h)", addr);
      void'(exp_q.pop_back());
    end
    req_valid = 1'b0;
  endtask

  // Scoreboard: compare each response as it is consumed
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bus_resp: got unexpected response %0h expected none", resp_data);
      end else begin
        check("bus_resp", 64'({resp_error, resp_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid4 && resp_ready) cap4 <= resp_data4;
  end

  initial begin
    logic [31:0] r1, r2, r3;
    int c0;

    vecs[0]  = '{1'b1, A_MSIP,         32'h0000_0001, 4'hF, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, A_MSIP,         32'h0,         4'h0, 32'h0000_0001,  1'b0};
    vecs[2]  = '{1'b1, A_MSIP,         32'h0,         4'h0, 32'h0,          1'b0};
    vecs[3]  = '{1'b0, A_MSIP,         32'h0,         4'h0, 32'h0000_0001,  1'b0};
    vecs[4]  = '{1'b1, A_MSIP,         32'hFFFF_FFFE, 4'hF, 32'h0,          1'b0};
    vecs[5]  = '{1'b0, A_MSIP,         32'h0,         4'h0, 32'h0,          1'b0};
    vecs[6]  = '{1'b1, A_CMP_LO,       32'h1122_3344, 4'hF, 32'h0,          1'b0};
    vecs[7]  = '{1'b0, A_CMP_LO,       32'h0,         4'h0, 32'h1122_3344,  1'b0};
    vecs[8]  = '{1'b1, A_CMP_HI,       32'hAABB_CCDD, 4'hC, 32'h0,          1'b0};
    vecs[9]  = '{1'b0, A_CMP_HI,       32'h0,         4'h0, 32'hAABB_FFFF,  1'b0};
    vecs[10] = '{1'b1, A_CMP_LO,       32'h5566_7788, 4'h5, 32'h0,          1'b0};
    vecs[11] = '{1'b0, 32'h0200_4002,  32'h0,         4'h0, 32'h1166_3388,  1'b0};
    vecs[12] = '{1'b0, 32'h0200_0010,  32'h0,         4'h0, 32'h0,          1'b1};
    vecs[13] = '{1'b1, 32'h0200_0010,  32'hDEAD_BEEF, 4'hF, 32'h0,          1'b1};
    vecs[14] = '{1'b0, 32'h0200_4008,  32'h0,         4'h0, 32'h0,          1'b1};
    vecs[15] = '{1'b0, 32'h0300_4000,  32'h0,         4'h0, 32'h0,          1'b1};

    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_address = '0;
    req_wdata = '0;
    req_strobe = '0;
    resp_ready = 1'b1;
    ext_irq = 1'b0;
    tick(3);
    reset = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_error", 64'(resp_error), 64'd0);
    check("rst_mtip", 64'(mtip), 64'd0);
    check("rst_msip", 64'(msip), 64'd0);
    check("rst_meip", 64'(meip), 64'd0);

    // mtime counting, TICK_DIV=1 (exact values) and TICK_DIV=4 (rate)
    bus_op(1'b1, A_TIME_LO, 32'h0, 4'hF, 32'h0, 1'b0);
    tick(3);
    bus_op(1'b0, A_TIME_LO, 32'h0, 4'h0, 32'd3, 1'b0);
    tick(7);
    r1 = cap4;
    bus_op(1'b0, A_TIME_LO, 32'h0, 4'h0, 32'd11, 1'b0);
    tick(3);
    r2 = cap4;
    bus_op(1'b0, A_TIME_LO, 32'h0, 4'h0, 32'd15, 1'b0);
    tick(1);
    r3 = cap4;
    check("div4_first_le1", 64'(r1 <= 32'd1), 64'd1);
    check("div4_8clk_delta", 64'(r2 - r1), 64'd2);
    check("div4_4clk_delta", 64'(r3 - r2), 64'd1);

    // Register map table (back-to-back accepts)
    foreach (vecs[i]) begin
      bus_op(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strobe,
             vecs[i].exp_data, vecs[i].exp_err);
    end
    tick(2);

    // Back-to-back: one accept per edge, response one edge later
    c0 = cyc;
    for (int i = 0; i < 3; i++) bus_op(1'b0, A_CMP_LO, 32'h0, 4'h0, 32'h1166_3388, 1'b0);
    check("b2b_cycles", 64'(cyc - c0), 64'd3);
    @(negedge clk);
    check("b2b_latency", 64'(resp_valid), 64'd1);
    tick(2);

    // Stalled response holds and blocks new requests
    resp_ready = 1'b0;
    bus_op(1'b0, A_CMP_HI, 32'h0, 4'h0, 32'hAABB_FFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_resp_valid", 64'(resp_valid), 64'd1);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_resp_data", 64'(resp_data), 64'hAABB_FFFF);
    end
    tick(1);
    resp_ready = 1'b1;
    tick(2);

    // Byte write to mtime lo on a tick edge: no increment, other bytes kept
    bus_op(1'b1, A_TIME_LO, 32'h1234_5600, 4'hF, 32'h0, 1'b0);
    bus_op(1'b1, A_TIME_LO, 32'h0000_0005, 4'h1, 32'h0, 1'b0);
    bus_op(1'b0, A_TIME_LO, 32'h0, 4'h0, 32'h1234_5605, 1'b0);
    tick(2);

    // Carry into hi and tear-free lo/hi read via shadow
    bus_op(1'b1, A_TIME_LO, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    bus_op(1'b1, A_TIME_HI, 32'h0, 4'hF, 32'h0, 1'b0);
    tick(2);
    bus_op(1'b0, A_TIME_LO, 32'h0, 4'h0, 32'd1, 1'b0);
    bus_op(1'b0, A_TIME_HI, 32'h0, 4'h0, 32'd1, 1'b0);
    tick(2);

    // Timer fire at mtime == 10 and clear by raising mtimecmp
    bus_op(1'b1, A_CMP_HI, 32'h0, 4'hF, 32'h0, 1'b0);
    bus_op(1'b1, A_CMP_LO, 32'd10, 4'hF, 32'h0, 1'b0);
    bus_op(1'b1, A_TIME_LO, 32'h0, 4'hF, 32'h0, 1'b0);
    bus_op(1'b1, A_TIME_HI, 32'h0, 4'hF, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mtip_at_9", 64'(mtip), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("mtip_at_10", 64'(mtip), 64'd1);
    tick(1);
    check("mtip_held", 64'(mtip), 64'd1);
    bus_op(1'b1, A_CMP_LO, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    check("mtip_cleared", 64'(mtip), 64'd0);
    tick(2);

    // Software and external interrupts
    bus_op(1'b1, A_MSIP, 32'h1, 4'h1, 32'h0, 1'b0);
    @(negedge clk);
    check("msip_set", 64'(msip), 64'd1);
    tick(1);
    ext_irq = 1'b1;
    for (int k = 1; k <= SYNC; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("meip_rise", 64'(meip), 64'(k == SYNC));
    end
    tick(1);
    ext_irq = 1'b0;
    for (int k = 1; k <= SYNC; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("meip_fall", 64'(meip), 64'(k != SYNC));
    end
    tick(1);

    // Reset in the middle of a stalled response
    bus_op(1'b1, A_CMP_HI, 32'h0, 4'hF, 32'h0, 1'b0);
    bus_op(1'b1, A_CMP_LO, 32'h0, 4'hF, 32'h0, 1'b0);
    tick(2);
    resp_ready = 1'b0;
    bus_op(1'b0, A_MSIP, 32'h0, 4'h0, 32'h1, 1'b0);
    @(negedge clk);
    check("pre_rst_resp_valid", 64'(resp_valid), 64'd1);
    check("pre_rst_mtip", 64'(mtip), 64'd1);
    tick(1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_mtip", 64'(mtip), 64'd0);
    check("mid_rst_msip", 64'(msip), 64'd0);
    tick(1);
    reset = 1'b0;
    resp_ready = 1'b1;
    bus_op(1'b0, A_TIME_LO, 32'h0, 4'h0, 32'h0, 1'b0);
    bus_op(1'b0, A_TIME_HI, 32'h0, 4'h0, 32'h0, 1'b0);
    bus_op(1'b0, A_CMP_LO, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0);
    bus_op(1'b0, A_CMP_HI, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0);
    bus_op(1'b0, A_MSIP, 32'h0, 4'h0, 32'h0, 1'b0);
    tick(3);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
